mem_bus_arbiter: RTL

Two-master, one-slave arbiter for the core's 32-bit memory bus, which uses split read and write channels: ren/raddr→rvalid/rdata and wen/waddr/wdata/wstrb→wready. It sits between the core's instruction-fetch port (m0), the data port (m1) and the shared memory/MMIO slave. It serialises accesses with round-robin fairness and one outstanding transaction. A watchdog terminates slave accesses that never respond.

---
 rtl/riscv_bus_pkg.sv | 29 ++
 rtl/mem_bus_arbiter_if.sv | 37 +++
 rtl/mem_bus_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscv_bus_pkg.sv
// Shared definitions for the core memory bus: widths, arbiter state encoding
// and the round-robin pick helper.
package riscv_bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_SW = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        WRITE = ST_WRITE
    } arb_state_t;

    typedef logic master_id_t;

    // On a tie the master that was not served last wins.
    function automatic master_id_t rr_pick(input logic [1:0] req, input master_id_t last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Split read/write memory bus bundle. The mem_* modports omit err, which only
// exists on the master-facing side of the arbiter.
interface mem_bus_arbiter_if;
    import riscv_bus_pkg::*;

    logic              ren;
    logic [BUS_AW-1:0] raddr;
    logic              rvalid;
    logic [BUS_DW-1:0] rdata;
    logic              wen;
    logic [BUS_AW-1:0] waddr;
    logic [BUS_DW-1:0] wdata;
    logic [BUS_SW-1:0] wstrb;
    logic              wready;
    logic              err;

    modport master (
        output ren, raddr, wen, waddr, wdata, wstrb,
        input  rvalid, rdata, wready, err
    );

    modport slave (
        input  ren, raddr, wen, waddr, wdata, wstrb,
        output rvalid, rdata, wready, err
    );

    modport mem_master (
        output ren, raddr, wen, waddr, wdata, wstrb,
        input  rvalid, rdata, wready
    );

    modport mem_slave (
        input  ren, raddr, wen, waddr, wdata, wstrb,
        output rvalid, rdata, wready
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter with one outstanding access and a watchdog
// that completes stalled slave accesses with an error.
module mem_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mem_bus_arbiter_if.slave     m0,
    mem_bus_arbiter_if.slave     m1,
    mem_bus_arbiter_if.mem_master s,
    output logic [1:0]           o_grant
);

    localparam int            CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT_CYCLES);
    localparam bit            WDOG_EN = (TIMEOUT_CYCLES > 0);

    arb_state_t    r_state;
    master_id_t    r_gnt;
    master_id_t    r_last;
    logic [CW-1:0] r_cnt;

    logic [1:0]        w_req;
    logic [1:0]        w_wreq;
    master_id_t        w_pick;
    logic              w_rd;
    logic              w_wr;
    logic              w_resp;
    logic              w_expire;
    logic              w_done;
    logic              w_sel_ren;
    logic              w_sel_wen;
    logic [BUS_AW-1:0] w_sel_raddr;
    logic [BUS_AW-1:0] w_sel_waddr;
    logic [BUS_DW-1:0] w_sel_wdata;
    logic [BUS_SW-1:0] w_sel_wstrb;
    logic              w_rvalid;
    logic              w_wready;
    logic [BUS_DW-1:0] w_rdata;

    assign w_req  = {m1.ren | m1.wen, m0.ren | m0.wen};
    assign w_wreq = {m1.wen, m0.wen};
    assign w_pick = rr_pick(w_req, r_last);

    assign w_rd = (r_state == READ);
    assign w_wr = (r_state == WRITE);

    // A slave answer always beats the watchdog in the same cycle.
    assign w_resp   = (w_rd & s.rvalid) | (w_wr & s.wready);
    assign w_expire = WDOG_EN && (w_rd | w_wr) && (r_cnt == TO_VAL) && !w_resp;
    assign w_done   = w_resp | w_expire;

    always_comb begin
        if (r_gnt) begin
            w_sel_ren   = m1.ren;
            w_sel_wen   = m1.wen;
            w_sel_raddr = m1.raddr;
            w_sel_waddr = m1.waddr;
            w_sel_wdata = m1.wdata;
            w_sel_wstrb = m1.wstrb;
        end else begin
            w_sel_ren   = m0.ren;
            w_sel_wen   = m0.wen;
            w_sel_raddr = m0.raddr;
            w_sel_waddr = m0.waddr;
            w_sel_wdata = m0.wdata;
            w_sel_wstrb = m0.wstrb;
        end
    end

    assign s.ren   = w_rd & w_sel_ren & ~w_expire;
    assign s.wen   = w_wr & w_sel_wen & ~w_expire;
    assign s.raddr = w_sel_raddr;
    assign s.waddr = w_sel_waddr;
    assign s.wdata = w_sel_wdata;
    assign s.wstrb = w_sel_wstrb;

    assign w_rvalid = w_rd & (s.rvalid | w_expire);
    assign w_wready = w_wr & (s.wready | w_expire);
    assign w_rdata  = (w_rd & s.rvalid) ? s.rdata : '0;

    // Only the owner sees completions; the other master reads all zeros.
    assign m0.rvalid = w_rvalid & ~r_gnt;
    assign m0.wready = w_wready & ~r_gnt;
    assign m0.err    = w_expire & ~r_gnt;
    assign m0.rdata  = r_gnt ? '0 : w_rdata;
    assign m1.rvalid = w_rvalid & r_gnt;
    assign m1.wready = w_wready & r_gnt;
    assign m1.err    = w_expire & r_gnt;
    assign m1.rdata  = r_gnt ? w_rdata : '0;

    assign o_grant = (r_state == IDLE) ? 2'b00 : (r_gnt ? 2'b10 : 2'b01);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_gnt   <= w_pick;
                        r_cnt   <= '0;
                        r_state <= w_wreq[w_pick] ? WRITE : READ;
                    end
                end
                READ, WRITE: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_last  <= r_gnt;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
